cache_controller: RTL
=====================

Name: cache_controller

Overview:
- Responder end of the memory-access handshake: the memory-access control unit raises enable with mem_read/mem_write, holds it, and waits for mem_ready.
- Direct-mapped, write-through, no-write-allocate data cache with one word per line.
- Sits between the MEM-stage control unit and the main-memory model.
- Misses and all writes go to main memory over a req/ack interface.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, word width.
- INDEX_W, 6, line-index bits, giving 2^INDEX_W lines. Tag is address[ADDR_W-1:INDEX_W+2]; address[1:0] is ignored.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  request from the MA control unit; level, held until mem_ready is seen.
- mem_read  in  1  read request qualifier.
- mem_write  in  1  write request qualifier.
- address  in  ADDR_W  byte address.
- write_data  in  DATA_W  store data.
- mem_ready  out  1  request complete; level.
- read_data  out  DATA_W  load result; valid while mem_ready=1.
- hit  out  1  last request hit; valid while mem_ready=1.
- mm_req  out  1  main-memory request.
- mm_we  out  1  main-memory write enable.
- mm_addr  out  ADDR_W  main-memory word address (byte address with [1:0]=0).
- mm_wdata  out  DATA_W  main-memory write data.
- mm_rdata  in  DATA_W  main-memory read data; valid with mm_ack.
- mm_ack  in  1  one-cycle completion pulse from main memory.
- hit_cnt  out  16  total hits, wraps at 16'hFFFF -> 0.
- miss_cnt  out  16  total read misses, wraps.

Behaviour:
- Reset (rst=1 at a rising edge):
  - All valid bits cleared in that one cycle; state to IDLE.
  - mem_ready=0, read_data=0, hit=0, mm_req=0, mm_we=0, mm_addr=0, mm_wdata=0, hit_cnt=0, miss_cnt=0.
  - Tag and data arrays are not cleared.
- FSM states: IDLE, LOOKUP, FILL, WR_THRU, DONE.
- IDLE:
  - enable=1 latches address, write_data and operation -> LOOKUP.
  - mem_write=1 wins when both qualifiers are high.
  - enable=1 with neither qualifier set -> DONE with no access and read_data unchanged.
- LOOKUP: index the line; hit = valid && tag match.
  - Read hit: read_data<=line data, hit<=1, hit_cnt++ -> DONE.
  - Read miss: hit<=0, miss_cnt++, mm_req<=1, mm_we<=0, mm_addr<=word address -> FILL.
  - Write: if hit, update the line data and hit_cnt++. In all cases mm_req<=1, mm_we<=1, mm_wdata<=latched data -> WR_THRU. hit reflects the lookup.
- FILL: on mm_ack, write data/tag/valid into the line, read_data<=mm_rdata, mm_req<=0 -> DONE.
- WR_THRU: on mm_ack, mm_req<=0, mm_we<=0 -> DONE.
- Main-memory rules:
  - mm_addr, mm_we and mm_wdata stay stable while mm_req=1.
  - mm_ack is honoured only in FILL/WR_THRU; ignored in any other state.
  - Ack latency is unbounded; the block waits indefinitely.
- DONE: mem_ready=1, held while enable=1. enable=0 -> mem_ready<=0 -> IDLE. This is a four-phase handshake, safe for a requester sampling on either clock edge.
- Latency, counted from the edge that samples enable:
  - Read hit: mem_ready high after the 2nd rising edge.
  - Miss or write: mem_ready high 1 edge after the mm_ack edge.
- Back-to-back requests: a new request is accepted only in IDLE, i.e. at least one cycle with enable=0 between requests.
- Input stability: changes to address/qualifiers after acceptance are ignored.
- Reset mid-operation: the transaction is aborted, mm_req drops the same edge, and no line is written. Main memory is reset alongside.
- Counters update only in LOOKUP.

Decomposition:
- Shared package cache_pkg:
  - state enum.
  - TAG_W = ADDR_W-INDEX_W-2.
  - field-extract constants for tag/index.
- Sub-module cache_line_store:
  - valid/tag/data arrays.
  - combinational read port.
  - one synchronous write port.
  - synchronous clear-all for valid bits.

Test Plan:
- Cold read miss: rst, then enable+mem_read, address=32'h0000_0040; main memory acks after 3 cycles with 32'hDEAD_BEEF -> mm_req=1 with mm_we=0 and mm_addr=32'h40; read_data=32'hDEAD_BEEF; hit=0; miss_cnt=1; mem_ready held until enable drops.
- Read hit: repeat the read of 32'h40 -> no mm_req; mem_ready after 2 edges; hit=1; hit_cnt=1.
- Write hit: write 32'h1234_5678 to 32'h40 -> mm_we=1, mm_wdata=32'h1234_5678; a following read of 32'h40 hits and returns 32'h1234_5678.
- Conflict eviction: with INDEX_W=6, read 32'h140 after 32'h40 (same index, different tag) -> miss and fill; a re-read of 32'h40 misses again.
- Write miss no-allocate: write 32'h0000_0200 -> memory written; a following read of 32'h200 misses.
- Reset mid-fill: rst asserted while in FILL with mm_req=1 -> mm_req=0 and mem_ready=0 the next cycle; a later mm_ack is ignored; a re-read of that address misses.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and address-field constants for the direct-mapped data cache.
package cache_pkg;

  localparam int unsigned ADDR_W_DEF  = 32;
  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned INDEX_W_DEF = 6;
  localparam int unsigned TAG_W       = ADDR_W_DEF - INDEX_W_DEF - 2;
  localparam int unsigned INDEX_LSB   = 2;
  localparam int unsigned TAG_LSB     = INDEX_LSB + INDEX_W_DEF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_FILL,
    ST_WR_THRU,
    ST_DONE
  } state_e;

endpackage

// File: rtl/cache_line_store.sv
// Valid/tag/data arrays: combinational read, one synchronous write, sync clear of valids.
module cache_line_store
  import cache_pkg::*;
#(
  parameter int unsigned INDEX_W = INDEX_W_DEF,
  parameter int unsigned TAG_WID = TAG_W,
  parameter int unsigned DATA_W  = DATA_W_DEF
) (
  input  logic               clk,
  input  logic               clr_valid,
  input  logic [INDEX_W-1:0] rd_idx,
  output logic               rd_valid,
  output logic [TAG_WID-1:0] rd_tag,
  output logic [DATA_W-1:0]  rd_data,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_idx,
  input  logic [TAG_WID-1:0] wr_tag,
  input  logic [DATA_W-1:0]  wr_data
);

  localparam int unsigned LINES = 1 << INDEX_W;

  logic [LINES-1:0]   valid_q, valid_d;
  logic [TAG_WID-1:0] tag_q  [LINES];
  logic [DATA_W-1:0]  data_q [LINES];

  always_comb begin
    valid_d = valid_q;
    if (clr_valid) begin
      valid_d = '0;
    end else if (wr_en) begin
      valid_d[wr_idx] = 1'b1;
    end
  end

  // Tag/data are deliberately not cleared; only the valid bits gate a hit.
  always_ff @(posedge clk) begin
    valid_q <= valid_d;
    if (wr_en && !clr_valid) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache with a four-phase requester handshake.
module cache_controller
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned INDEX_W = INDEX_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  output logic              mem_ready,
  output logic [DATA_W-1:0] read_data,
  output logic              hit,
  output logic              mm_req,
  output logic              mm_we,
  output logic [ADDR_W-1:0] mm_addr,
  output logic [DATA_W-1:0] mm_wdata,
  input  logic [DATA_W-1:0] mm_rdata,
  input  logic              mm_ack,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt
);

  localparam int unsigned TAG_W_L   = ADDR_W - INDEX_W - 2;
  localparam int unsigned TAG_LSB_L = INDEX_LSB + INDEX_W;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                is_wr_q, is_wr_d;
  logic                mem_ready_q, mem_ready_d;
  logic [DATA_W-1:0]   read_data_q, read_data_d;
  logic                hit_q, hit_d;
  logic                mm_req_q, mm_req_d;
  logic                mm_we_q, mm_we_d;
  logic [ADDR_W-1:0]   mm_addr_q, mm_addr_d;
  logic [DATA_W-1:0]   mm_wdata_q, mm_wdata_d;
  logic [15:0]         hit_cnt_q, hit_cnt_d;
  logic [15:0]         miss_cnt_q, miss_cnt_d;

  logic                st_valid;
  logic [TAG_W_L-1:0]  st_tag;
  logic [DATA_W-1:0]   st_rdata;
  logic                st_wr_en;
  logic [DATA_W-1:0]   st_wr_data;
  logic [INDEX_W-1:0]  line_idx;
  logic [TAG_W_L-1:0]  line_tag;
  logic                lookup_hit;

  assign line_idx   = addr_q[TAG_LSB_L-1:INDEX_LSB];
  assign line_tag   = addr_q[ADDR_W-1:TAG_LSB_L];
  assign lookup_hit = st_valid && (st_tag == line_tag);

  cache_line_store #(
    .INDEX_W (INDEX_W),
    .TAG_WID (TAG_W_L),
    .DATA_W  (DATA_W)
  ) u_store (
    .clk       (clk),
    .clr_valid (rst),
    .rd_idx    (line_idx),
    .rd_valid  (st_valid),
    .rd_tag    (st_tag),
    .rd_data   (st_rdata),
    .wr_en     (st_wr_en && !rst),
    .wr_idx    (line_idx),
    .wr_tag    (line_tag),
    .wr_data   (st_wr_data)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    is_wr_d     = is_wr_q;
    mem_ready_d = mem_ready_q;
    read_data_d = read_data_q;
    hit_d       = hit_q;
    mm_req_d    = mm_req_q;
    mm_we_d     = mm_we_q;
    mm_addr_d   = mm_addr_q;
    mm_wdata_d  = mm_wdata_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    st_wr_en    = 1'b0;
    st_wr_data  = wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          addr_d  = {address[ADDR_W-1:2], 2'b00};
          wdata_d = write_data;
          is_wr_d = mem_write;
          if (mem_write || mem_read) begin
            state_d = ST_LOOKUP;
          end else begin
            mem_ready_d = 1'b1;
            state_d     = ST_DONE;
          end
        end
      end
      ST_LOOKUP: begin
        hit_d = lookup_hit;
        if (is_wr_q) begin
          if (lookup_hit) begin
            st_wr_en  = 1'b1;
            hit_cnt_d = hit_cnt_q + 16'd1;
          end
          mm_req_d   = 1'b1;
          mm_we_d    = 1'b1;
          mm_addr_d  = addr_q;
          mm_wdata_d = wdata_q;
          state_d    = ST_WR_THRU;
        end else if (lookup_hit) begin
          read_data_d = st_rdata;
          hit_cnt_d   = hit_cnt_q + 16'd1;
          mem_ready_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          miss_cnt_d = miss_cnt_q + 16'd1;
          mm_req_d   = 1'b1;
          mm_we_d    = 1'b0;
          mm_addr_d  = addr_q;
          state_d    = ST_FILL;
        end
      end
      ST_FILL: begin
        if (mm_ack) begin
          st_wr_en    = 1'b1;
          st_wr_data  = mm_rdata;
          read_data_d = mm_rdata;
          mm_req_d    = 1'b0;
          mem_ready_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_WR_THRU: begin
        if (mm_ack) begin
          mm_req_d    = 1'b0;
          mm_we_d     = 1'b0;
          mem_ready_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!enable) begin
          mem_ready_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      is_wr_q     <= 1'b0;
      mem_ready_q <= 1'b0;
      read_data_q <= '0;
      hit_q       <= 1'b0;
      mm_req_q    <= 1'b0;
      mm_we_q     <= 1'b0;
      mm_addr_q   <= '0;
      mm_wdata_q  <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      is_wr_q     <= is_wr_d;
      mem_ready_q <= mem_ready_d;
      read_data_q <= read_data_d;
      hit_q       <= hit_d;
      mm_req_q    <= mm_req_d;
      mm_we_q     <= mm_we_d;
      mm_addr_q   <= mm_addr_d;
      mm_wdata_q  <= mm_wdata_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  assign mem_ready = mem_ready_q;
  assign read_data = read_data_q;
  assign hit       = hit_q;
  assign mm_req    = mm_req_q;
  assign mm_we     = mm_we_q;
  assign mm_addr   = mm_addr_q;
  assign mm_wdata  = mm_wdata_q;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

endmodule
